// File: rtl/keypad_scan_encoder_pkg.sv
// Shared types and helpers for the matrix keypad scanner/encoder.
// The FSM state and scan candidate enums are separate so their names never collide.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_MULTI    = 2'd2
  } key_state_e;

  typedef enum logic [1:0] {
    CAND_NONE   = 2'd0,
    CAND_SINGLE = 2'd1,
    CAND_MULTI  = 2'd2
  } cand_kind_e;

  function automatic int code_of(input int col, input int row, input int rows);
    return col * rows + row;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Key event bundle produced by the scanner and consumed by the display path.
interface keypad_scan_encoder_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_release;
  logic              key_held;
  logic              multi_key;

  modport master (output key_code, key_valid, key_release, key_held, multi_key);
  modport slave  (input  key_code, key_valid, key_release, key_held, multi_key);
endinterface

// File: rtl/keypad_scan_encoder_debounce.sv
// Whole-scan debouncer and commit FSM; owns every key_* output register.
// A roll-over emits the release of the old key, then the new key's valid one cycle later.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_end,
  input  cand_kind_e        cand_kind,
  input  logic [CODE_W-1:0] cand_code,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  cand_kind_e        prev_kind_r;
  logic [CODE_W-1:0] prev_code_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              same_s;
  logic              commit_s;

  key_state_e        state_r;
  logic              pend_r;
  logic [CODE_W-1:0] pend_code_r;
  logic [CODE_W-1:0] key_code_r;
  logic              key_valid_r;
  logic              key_release_r;
  logic              key_held_r;
  logic              multi_key_r;

  // Compare against the previous scan's candidate and derive the commit strobe.
  always_comb begin
    same_s = (cand_kind == prev_kind_r) &&
             ((cand_kind != CAND_SINGLE) || (cand_code == prev_code_r));
    if (same_s) begin
      cnt_next_s = (cnt_r == CNT_W'(DEBOUNCE_SCANS)) ? cnt_r : cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = CNT_W'(1);
    end
    commit_s = scan_end && (cnt_next_s == CNT_W'(DEBOUNCE_SCANS));
  end

  // Remember the last candidate and its saturating stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_kind_r <= CAND_NONE;
      prev_code_r <= '0;
      cnt_r       <= '0;
    end else if (scan_end) begin
      prev_kind_r <= cand_kind;
      prev_code_r <= cand_code;
      cnt_r       <= cnt_next_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Commit FSM; a pending roll-over key is always flushed before the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RELEASED;
      pend_r        <= 1'b0;
      pend_code_r   <= '0;
      key_code_r    <= '0;
      key_valid_r   <= 1'b0;
      key_release_r <= 1'b0;
      key_held_r    <= 1'b0;
      multi_key_r   <= 1'b0;
    end else begin
      key_valid_r   <= 1'b0;
      key_release_r <= 1'b0;
      if (pend_r) begin
        pend_r      <= 1'b0;
        key_valid_r <= 1'b1;
        key_code_r  <= pend_code_r;
      end else if (commit_s) begin
        case (state_r)
          ST_RELEASED: begin
            if (cand_kind == CAND_SINGLE) begin
              state_r     <= ST_PRESSED;
              key_code_r  <= cand_code;
              key_valid_r <= 1'b1;
              key_held_r  <= 1'b1;
            end else if (cand_kind == CAND_MULTI) begin
              state_r     <= ST_MULTI;
              multi_key_r <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (cand_kind == CAND_NONE) begin
              state_r       <= ST_RELEASED;
              key_release_r <= 1'b1;
              key_held_r    <= 1'b0;
            end else if ((cand_kind == CAND_SINGLE) && (cand_code != key_code_r)) begin
              key_release_r <= 1'b1;
              pend_r        <= 1'b1;
              pend_code_r   <= cand_code;
            end else if (cand_kind == CAND_MULTI) begin
              state_r       <= ST_MULTI;
              key_release_r <= 1'b1;
              key_held_r    <= 1'b0;
              multi_key_r   <= 1'b1;
            end
          end
          ST_MULTI: begin
            // Only a complete release leaves MULTI, so a ghost single never emits a code.
            if (cand_kind == CAND_NONE) begin
              state_r     <= ST_RELEASED;
              multi_key_r <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_RELEASED;
          end
        endcase
      end
    end
  end

  assign key_code    = key_code_r;
  assign key_valid   = key_valid_r;
  assign key_release = key_release_r;
  assign key_held    = key_held_r;
  assign multi_key   = multi_key_r;

endmodule

// File: rtl/keypad_scan_encoder.sv
// Matrix keypad scanner: column driver, row synchroniser, scan snapshot and encoder.
// Rows are sampled on the last cycle of each column slot; a full scan is classified once.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_drive,
  input  logic [ROWS-1:0] row_sense,
  keypad_scan_encoder_if.master key_if
);

  localparam int N      = ROWS * COLS;
  localparam int CODE_W = $clog2(N);
  localparam int COL_W  = $clog2(COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int PW     = $clog2(N + 1);

  if ((SCAN_DIV < 3) || (COLS < 2) || (DEBOUNCE_SCANS < 1) || (ROWS < 1)) begin : g_param_err
    $fatal(1, "keypad_scan_encoder: illegal parameter set");
  end

  logic [ROWS-1:0]   sync1_r;
  logic [ROWS-1:0]   sync2_r;
  logic              run_r;
  logic [COL_W-1:0]  col_idx_r;
  logic [COL_W-1:0]  col_next_s;
  logic [DIV_W-1:0]  div_r;
  logic [COLS-1:0]   col_drive_r;
  logic [N-1:0]      snap_r;
  logic [N-1:0]      snap_next_s;
  logic              slot_end_s;
  logic              scan_end_s;
  logic [PW-1:0]     pop_s;
  logic [CODE_W-1:0] enc_code_s;
  cand_kind_e        cand_kind_s;
  logic [CODE_W-1:0] key_code_s;
  logic              key_valid_s;
  logic              key_release_s;
  logic              key_held_s;
  logic              multi_key_s;

  assign slot_end_s = run_r && (div_r == DIV_W'(SCAN_DIV - 1));
  assign scan_end_s = slot_end_s && (col_idx_r == COL_W'(COLS - 1));
  assign col_next_s = (col_idx_r == COL_W'(COLS - 1)) ? '0 : col_idx_r + COL_W'(1);

  // Two-flop synchroniser; idle level is all-ones (no row pulled low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= row_sense;
      sync2_r <= sync1_r;
    end
  end

  // Column slot sequencer; run_r lets column 0 get a full slot right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      col_idx_r   <= '0;
      div_r       <= '0;
      col_drive_r <= '1;
    end else if (!run_r) begin
      run_r       <= 1'b1;
      col_drive_r <= ~COLS'(1);
    end else if (slot_end_s) begin
      div_r       <= '0;
      col_idx_r   <= col_next_s;
      col_drive_r <= ~(COLS'(1) << col_next_s);
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Merge the current column's sampled rows into the snapshot (1 = pressed).
  always_comb begin
    snap_next_s = snap_r;
    if (slot_end_s) begin
      for (int r = 0; r < ROWS; r++) begin
        snap_next_s[code_of(int'(col_idx_r), r, ROWS)] = ~sync2_r[r];
      end
    end else begin
      snap_next_s = snap_r;
    end
  end

  // Snapshot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= '0;
    end else begin
      snap_r <= snap_next_s;
    end
  end

  // Popcount and encoder over the completed scan, last column included.
  always_comb begin
    pop_s      = '0;
    enc_code_s = '0;
    for (int i = 0; i < N; i++) begin
      pop_s = pop_s + PW'(snap_next_s[i]);
      if (snap_next_s[i]) begin
        enc_code_s = CODE_W'(i);
      end else begin
        enc_code_s = enc_code_s;
      end
    end
    if (pop_s == '0) begin
      cand_kind_s = CAND_NONE;
    end else if (pop_s == PW'(1)) begin
      cand_kind_s = CAND_SINGLE;
    end else begin
      cand_kind_s = CAND_MULTI;
    end
  end

  keypad_debounce #(
    .CODE_W        (CODE_W),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_end   (scan_end_s),
    .cand_kind  (cand_kind_s),
    .cand_code  (enc_code_s),
    .key_code   (key_code_s),
    .key_valid  (key_valid_s),
    .key_release(key_release_s),
    .key_held   (key_held_s),
    .multi_key  (multi_key_s)
  );

  assign col_drive          = col_drive_r;
  assign key_if.key_code    = key_code_s;
  assign key_if.key_valid   = key_valid_s;
  assign key_if.key_release = key_release_s;
  assign key_if.key_held    = key_held_s;
  assign key_if.multi_key   = multi_key_s;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Self-checking bench: a virtual 4x4 key matrix, a per-scan behavioural model
// checked every cycle, directed scenarios with literal expectations, then random key traffic.
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_drive;
  logic [3:0]  row_sense;
  logic [15:0] mask = 16'h0000;

  keypad_scan_encoder_if #(.CODE_W(4)) kif ();

  keypad_scan_encoder #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_drive(col_drive),
    .row_sense(row_sense),
    .key_if   (kif)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_sense = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_drive[c] && mask[c*4+r]) row_sense[r] = 1'b0;
  end

  // Cycles since reset release: cycle t follows the t-th rising edge.
  int t = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  // Model state: per-scan view of the matrix, debounce and key state.
  logic [15:0] snap_m;
  int          m_state, m_cnt, m_pk, m_pc;
  logic [3:0]  m_code, m_pend_code, exp_col;
  logic        m_valid, m_rel, m_held, m_multi, m_pend;
  logic [11:0] exp_v, act_v;

  int n_valid = 0, n_rel = 0, last_valid_t = 0, last_rel_t = 0;
  logic [3:0] last_valid_code = 4'h0, last_rel_code = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    else n_pass++;
  endtask

  task automatic model_scan();
    int pc, kind, code;
    bit same;
    pc = $countones(snap_m);
    kind = (pc == 0) ? 0 : ((pc == 1) ? 1 : 2);
    code = 0;
    for (int i = 0; i < 16; i++) if (snap_m[i]) code = i;
    same = (kind == m_pk) && ((kind != 1) || (code == m_pc));
    m_cnt = same ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 1;
    m_pk = kind;
    m_pc = code;
    if (m_cnt == 3) begin
      case (m_state)
        0: if (kind == 1) begin m_state = 1; m_code = 4'(code); m_valid = 1; m_held = 1; end
           else if (kind == 2) begin m_state = 2; m_multi = 1; end
        1: if (kind == 0) begin m_state = 0; m_rel = 1; m_held = 0; end
           else if (kind == 1 && 4'(code) != m_code) begin m_rel = 1; m_pend = 1; m_pend_code = 4'(code); end
           else if (kind == 2) begin m_state = 2; m_rel = 1; m_held = 0; m_multi = 1; end
        2: if (kind == 0) begin m_state = 0; m_multi = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  // One cycle: update the model at the falling edge, compare, record DUT pulses.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_pk = 0; m_pc = 0; m_code = 4'h0; m_pend_code = 4'h0;
      m_valid = 0; m_rel = 0; m_held = 0; m_multi = 0; m_pend = 0; snap_m = 16'h0;
      exp_col = 4'hF;
    end else begin
      m_valid = 0;
      m_rel = 0;
      if (m_pend) begin m_valid = 1; m_code = m_pend_code; m_pend = 0; end
      // Rows seen in a slot's second cycle reach the sample point after the 2-flop sync.
      if (t >= 1 && (t - 1) % 4 == 1)
        for (int r = 0; r < 4; r++) snap_m[((t-1)/4%4)*4+r] = mask[((t-1)/4%4)*4+r];
      if (t >= 17 && (t - 1) % 16 == 0) model_scan();
      exp_col = (t == 0) ? 4'hF : (4'hF ^ (4'b0001 << ((t - 1) / 4 % 4)));
    end
    exp_v = {exp_col, m_code, m_valid, m_rel, m_held, m_multi};
    act_v = {col_drive, kif.key_code, kif.key_valid, kif.key_release, kif.key_held, kif.multi_key};
    chk("cycle_outputs", 32'(act_v), 32'(exp_v));
    if (kif.key_valid)   begin n_valid++; last_valid_code = kif.key_code; last_valid_t = t; end
    if (kif.key_release) begin n_rel++;   last_rel_code = kif.key_code;   last_rel_t = t;   end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [15:0] m, input int cycles);
    mask = m;
    repeat (cycles) step();
  endtask

  // Asynchronous reset in the middle of a cycle, then release between edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col_drive", 32'(col_drive), 32'hF);
    chk("rst_key_outs", 32'({kif.key_code, kif.key_valid, kif.key_release, kif.key_held, kif.multi_key}), 32'h0);
    step();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_col_after_reset", 32'(col_drive), 32'b1110);
  endtask

  localparam int SCAN = 16;

  initial begin
    int v0, r0;
    logic [15:0] m, prev_m;
    @(posedge clk);
    #1;
    do_reset();

    // Clean press of col2,row1.
    hold(16'h0000, 2 * SCAN);
    v0 = n_valid; r0 = n_rel;
    hold(16'h0001 << 9, 6 * SCAN);
    chk("press9_valid_count", 32'(n_valid - v0), 32'd1);
    chk("press9_code", 32'(last_valid_code), 32'd9);
    chk("press9_model_code", 32'(m_code), 32'd9);
    chk("press9_held", 32'(kif.key_held), 32'd1);
    hold(16'h0000, 6 * SCAN);
    chk("release9_count", 32'(n_rel - r0), 32'd1);
    chk("release9_code", 32'(last_rel_code), 32'd9);

    // Bounce on key 6, then stable.
    v0 = n_valid;
    for (int i = 0; i < 3; i++) begin
      hold(16'h0001 << 6, 20);
      hold(16'h0000, 20);
    end
    chk("bounce_no_pulse", 32'(n_valid - v0), 32'd0);
    hold(16'h0001 << 6, 4 * SCAN);
    chk("bounce_settled_valid", 32'(n_valid - v0), 32'd1);
    chk("bounce_settled_code", 32'(last_valid_code), 32'd6);
    hold(16'h0000, 6 * SCAN);

    // Two keys together, drop to one, full release.
    v0 = n_valid; r0 = n_rel;
    hold(16'h8001, 6 * SCAN);
    chk("multi_set", 32'(kif.multi_key), 32'd1);
    hold(16'h8000, 6 * SCAN);
    chk("multi_ghost_hold", 32'(kif.multi_key), 32'd1);
    hold(16'h0000, 6 * SCAN);
    chk("multi_cleared", 32'(kif.multi_key), 32'd0);
    chk("multi_no_valid", 32'(n_valid - v0), 32'd0);
    chk("multi_no_release", 32'(n_rel - r0), 32'd0);

    // Roll-over from key 3 straight to key 12.
    hold(16'h0001 << 3, 6 * SCAN);
    hold(16'h0001 << 12, 6 * SCAN);
    chk("roll_release_code", 32'(last_rel_code), 32'd3);
    chk("roll_valid_code", 32'(last_valid_code), 32'd12);
    chk("roll_valid_next_cycle", 32'(last_valid_t - last_rel_t), 32'd1);
    hold(16'h0000, 6 * SCAN);

    // Glitch shorter than one scan.
    v0 = n_valid;
    hold(16'h0001 << 10, 10);
    hold(16'h0000, 6 * SCAN);
    chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_not_held", 32'(kif.key_held), 32'd0);

    // Reset while a key is held.
    hold(16'h0001 << 5, 6 * SCAN);
    chk("pre_reset_held", 32'(kif.key_held), 32'd1);
    do_reset();
    hold(16'h0001 << 5, 6 * SCAN);
    hold(16'h0000, 6 * SCAN);

    // Random key traffic: none, single, pairs, repeats and short glitches.
    prev_m = 16'h0000;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1: m = 16'h0001 << $urandom_range(0, 15);
        2: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: m = prev_m;
      endcase
      hold(m, $urandom_range(3, 60));
      prev_m = m;
    end
    hold(16'h0000, 6 * SCAN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
